// File: rtl/pinwheel_regfile_mp.sv
// pinwheel_regfile_mp: multi-threaded register file with several synchronous
// read ports, one write port, write-first bypass, hard-wired zero register per
// thread, and a clear engine that zeroes the whole file after reset or one
// thread's bank on request.
//
// Handshake: clear_req is a one-cycle request sampled only while busy=0; while
// busy=1 the clear engine owns the write port, so external writes and further
// clear requests are dropped (never queued). clear_done pulses in the cycle of
// the last sweep write, and busy drops in the following cycle.
module pinwheel_regfile_mp #(
    parameter int reg_count    = 32,
    parameter int reg_width    = 32,
    parameter int thread_count = 4,
    parameter int read_ports   = 2,
    localparam int reg_total   = reg_count * thread_count,
    localparam int addr_bits   = $clog2(reg_total),
    localparam int tid_bits    = (thread_count > 1) ? $clog2(thread_count) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [read_ports*addr_bits-1:0] raddr,
    output logic [read_ports*reg_width-1:0] rdata,
    input  logic [addr_bits-1:0]            waddr,
    input  logic [reg_width-1:0]            wdata,
    input  logic                            wren,
    input  logic                            clear_req,
    input  logic [tid_bits-1:0]             clear_tid,
    output logic                            busy,
    output logic                            clear_done
);

    // Width of the register index inside an address ({thread, index}).
    localparam int idx_bits = $clog2(reg_count);

    localparam logic [addr_bits-1:0] last_total  = addr_bits'(reg_total - 1);
    localparam logic [addr_bits-1:0] last_thread = addr_bits'(reg_count - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [addr_bits-1:0]   cnt_q, cnt_d;
    logic [tid_bits-1:0]    tid_q, tid_d;

    logic [addr_bits-1:0]   clr_base;
    logic [addr_bits-1:0]   sweep_addr;

    logic                   we_eff;
    logic [addr_bits-1:0]   wa_eff;
    logic [reg_width-1:0]   wd_eff;

    logic [reg_width-1:0]   byp_q;

    // Base address of the thread being cleared; the thread field drops out
    // entirely when there is only one thread.
    assign clr_base   = addr_bits'(tid_q) << idx_bits;
    assign sweep_addr = (state_q == ST_INIT) ? cnt_q : (clr_base | cnt_q);

    // Sweep state register; reset restarts the full-file sweep from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tid_q   <= tid_d;
        end
    end

    // Next-state logic for the clear engine plus busy / clear_done outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tid_d      = tid_q;
        busy       = 1'b1;
        clear_done = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == last_total) begin
                    clear_done = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + addr_bits'(1);
                end
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (clear_req) begin
                    tid_d   = clear_tid;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == last_thread) begin
                    clear_done = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + addr_bits'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_INIT;
            end
        endcase
    end

    // Single effective write: the sweep owns the port while busy, otherwise
    // an external write to any non-zero register index.
    always_comb begin
        we_eff = 1'b0;
        wa_eff = waddr;
        wd_eff = wdata;
        if (busy) begin
            we_eff = 1'b1;
            wa_eff = sweep_addr;
            wd_eff = '0;
        end else if (wren && (waddr[idx_bits-1:0] != '0)) begin
            we_eff = 1'b1;
        end
    end

    // Captured write data, shared by all ports for the write-first bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_q <= '0;
        end else begin
            byp_q <= wd_eff;
        end
    end

    for (genvar p = 0; p < read_ports; p++) begin : g_port
        logic [reg_width-1:0] mem [reg_total];
        logic [addr_bits-1:0] ra;
        logic [reg_width-1:0] mem_rd_q;
        logic                 zero_q;
        logic                 hit_q;

        assign ra = raddr[p*addr_bits +: addr_bits];

        // Private storage copy for this port: plain write plus registered
        // read-old access, no reset, so it maps onto a block RAM.
        always_ff @(posedge clk) begin
            if (we_eff) begin
                mem[wa_eff] <= wd_eff;
            end
            mem_rd_q <= mem[ra];
        end

        // Output select flags; reset forces the port to read zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                zero_q <= 1'b1;
                hit_q  <= 1'b0;
            end else begin
                zero_q <= (ra[idx_bits-1:0] == '0);
                hit_q  <= we_eff && (wa_eff == ra);
            end
        end

        // Index 0 wins over the bypass; the bypass wins over the RAM output.
        assign rdata[p*reg_width +: reg_width] =
            zero_q ? '0 : (hit_q ? byp_q : mem_rd_q);
    end

endmodule

// File: tb/tb_pinwheel_regfile_mp.sv
// tb_pinwheel_regfile_mp: directed and randomized checks of the register file
// against a work-queue reference model (pending sweep addresses in a queue,
// register contents in a plain array).
module tb_pinwheel_regfile_mp;

    localparam int RC = 32;
    localparam int RW = 32;
    localparam int TC = 4;
    localparam int RP = 3;
    localparam int RT = RC * TC;
    localparam int AB = $clog2(RT);
    localparam int TB = $clog2(TC);

    logic               clk;
    logic               rst;
    logic [RP*AB-1:0]   raddr;
    logic [RP*RW-1:0]   rdata;
    logic [AB-1:0]      waddr;
    logic [RW-1:0]      wdata;
    logic               wren;
    logic               clear_req;
    logic [TB-1:0]      clear_tid;
    logic               busy;
    logic               clear_done;

    int checks;
    int failures;

    logic [RW-1:0] model [RT];
    bit            known [RT];
    int            sweep_q[$];
    logic [RW-1:0] exp_q [RP];
    bit            exp_ok [RP];

    pinwheel_regfile_mp #(
        .reg_count    (RC),
        .reg_width    (RW),
        .thread_count (TC),
        .read_ports   (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raddr      (raddr),
        .rdata      (rdata),
        .waddr      (waddr),
        .wdata      (wdata),
        .wren       (wren),
        .clear_req  (clear_req),
        .clear_tid  (clear_tid),
        .busy       (busy),
        .clear_done (clear_done)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int mk(int t, int r);
        return t * RC + r;
    endfunction

    // Model after reset: every address waits to be zeroed, nothing known yet,
    // and the reset read value is zero.
    task automatic model_reset();
        sweep_q.delete();
        for (int a = 0; a < RT; a++) begin
            sweep_q.push_back(a);
            known[a] = 1'b0;
        end
        for (int p = 0; p < RP; p++) begin
            exp_q[p]  = '0;
            exp_ok[p] = 1'b1;
        end
    endtask

    // Advance one clock: apply this cycle's write to the model, compute the
    // read results the ports should show next, and move to the next negedge.
    task automatic tick();
        int a;
        if (sweep_q.size() != 0) begin
            a = sweep_q.pop_front();
            model[a] = '0;
            known[a] = 1'b1;
        end else begin
            if (wren && (int'(waddr) % RC) != 0) begin
                model[int'(waddr)] = wdata;
                known[int'(waddr)] = 1'b1;
            end
            if (clear_req) begin
                for (int i = 0; i < RC; i++) sweep_q.push_back(int'(clear_tid) * RC + i);
            end
        end
        for (int p = 0; p < RP; p++) begin
            a = int'(raddr[p*AB +: AB]);
            exp_ok[p] = known[a] || (a % RC == 0);
            exp_q[p]  = (a % RC == 0) ? '0 : model[a];
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wren      = 1'b0;
        clear_req = 1'b0;
        clear_tid = '0;
        waddr     = '0;
        wdata     = '0;
        raddr     = '0;
    endtask

    task automatic test_reset();
        int nbusy;
        int done_at;
        int done_cnt;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++;
        if (clear_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", clear_done); end
        checks++;
        if (rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        model_reset();
        rst = 1'b0;
        nbusy = 0; done_at = -1; done_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            if (busy !== 1'b1) break;
            nbusy++;
            if (clear_done === 1'b1) begin done_cnt++; done_at = nbusy; end
            checks++;
            if (clear_done !== (sweep_q.size() == 1)) begin
                failures++;
                $display("FAIL init_done_cycle%0d: got %b want %b", nbusy, clear_done, sweep_q.size() == 1);
            end
            tick();
        end
        checks++;
        if (nbusy != RT) begin failures++; $display("FAIL init_busy_len: got %0d want %0d", nbusy, RT); end
        checks++;
        if (done_at != RT || done_cnt != 1) begin
            failures++;
            $display("FAIL init_done: got at=%0d count=%0d want at=%0d count=1", done_at, done_cnt, RT);
        end
        // Every entry must read zero once the sweep has finished.
        for (int a = 0; a < RT; a += RP) begin
            for (int p = 0; p < RP; p++) raddr[p*AB +: AB] = AB'((a + p) % RT);
            tick();
            for (int p = 0; p < RP; p++) begin
                checks++;
                if (rdata[p*RW +: RW] !== '0) begin
                    failures++;
                    $display("FAIL init_zero a=%0d: got %h want 0", (a + p) % RT, rdata[p*RW +: RW]);
                end
            end
        end
    endtask

    task automatic test_bypass();
        waddr = AB'(mk(2, 5));
        wdata = 32'hDEADBEEF;
        wren  = 1'b1;
        raddr[0*AB +: AB] = AB'(mk(2, 5));
        raddr[1*AB +: AB] = AB'(mk(2, 5));
        raddr[2*AB +: AB] = AB'(mk(2, 6));
        tick();
        wren = 1'b0;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (rdata[p*RW +: RW] !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL bypass_p%0d: got %h want deadbeef", p, rdata[p*RW +: RW]);
            end
        end
        checks++;
        if (rdata[2*RW +: RW] !== exp_q[2]) begin
            failures++;
            $display("FAIL bypass_other: got %h want %h", rdata[2*RW +: RW], exp_q[2]);
        end
        tick();
        checks++;
        if (rdata[0 +: RW] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL stored_after_bypass: got %h want deadbeef", rdata[0 +: RW]);
        end
    endtask

    task automatic test_zero_reg();
        waddr = AB'(mk(1, 0));
        wdata = 32'h00001234;
        wren  = 1'b1;
        for (int p = 0; p < RP; p++) raddr[p*AB +: AB] = AB'(mk(1, 0));
        tick();
        wren = 1'b0;
        for (int p = 0; p < RP; p++) begin
            checks++;
            if (rdata[p*RW +: RW] !== '0) begin
                failures++;
                $display("FAIL zero_reg_bypass_p%0d: got %h want 0", p, rdata[p*RW +: RW]);
            end
        end
        tick();
        checks++;
        if (rdata[0 +: RW] !== '0) begin
            failures++;
            $display("FAIL zero_reg_stored: got %h want 0", rdata[0 +: RW]);
        end
    endtask

    task automatic test_clear();
        int n;
        int done_at;
        // Fill thread 3 with index values and scatter data into threads 0..2.
        for (int r = 1; r < RC; r++) begin
            waddr = AB'(mk(3, r));
            wdata = RW'(r);
            wren  = 1'b1;
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            waddr = AB'(mk($urandom_range(0, 2), $urandom_range(1, RC - 1)));
            wdata = $urandom;
            tick();
        end
        wren = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL clear_pre_busy: got %b want 0", busy); end
        clear_req = 1'b1;
        clear_tid = TB'(3);
        tick();
        clear_req = 1'b0;
        n = 0; done_at = -1;
        for (int c = 0; c < 100; c++) begin
            if (busy !== 1'b1) break;
            n++;
            if (clear_done === 1'b1) done_at = n;
            // The entry being zeroed this cycle, the next one, and a neighbour.
            raddr[0*AB +: AB] = AB'(mk(3, n - 1));
            raddr[1*AB +: AB] = AB'(mk(3, n % RC));
            raddr[2*AB +: AB] = AB'(mk(0, 9));
            wren  = (n == 5);
            waddr = (n == 5) ? AB'(mk(3, 7)) : AB'(mk(0, 9));
            wdata = 32'hFFFF0000 | RW'(n);
            if (n == 5) waddr = AB'(mk(3, 7));
            if (n == 6) begin wren = 1'b1; waddr = AB'(mk(0, 9)); end
            clear_req = (n == 8);
            clear_tid = '0;
            tick();
            for (int p = 0; p < RP; p++) begin
                checks++;
                if (exp_ok[p] && rdata[p*RW +: RW] !== exp_q[p]) begin
                    failures++;
                    $display("FAIL clear_sweep_read n=%0d p=%0d: got %h want %h", n, p, rdata[p*RW +: RW], exp_q[p]);
                end
            end
        end
        wren = 1'b0;
        clear_req = 1'b0;
        checks++;
        if (n != RC) begin failures++; $display("FAIL clear_busy_len: got %0d want %0d", n, RC); end
        checks++;
        if (done_at != RC) begin failures++; $display("FAIL clear_done_at: got %0d want %0d", done_at, RC); end
        // Read back every register; thread 3 must be zero, others as written.
        for (int a = 0; a < RT; a += RP) begin
            for (int p = 0; p < RP; p++) raddr[p*AB +: AB] = AB'((a + p) % RT);
            tick();
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL clear_not_requeued: got %b want 0", busy); end
            for (int p = 0; p < RP; p++) begin
                checks++;
                if (rdata[p*RW +: RW] !== exp_q[p] ||
                    ((a + p) % RT >= mk(3, 0) && rdata[p*RW +: RW] !== '0)) begin
                    failures++;
                    $display("FAIL clear_readback a=%0d: got %h want %h", (a + p) % RT, rdata[p*RW +: RW], exp_q[p]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int nbusy;
        int done_cnt;
        clear_req = 1'b1;
        clear_tid = TB'(1);
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        // Asynchronous assertion in the middle of the low clock phase.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midclear_rst_busy: got %b want 1", busy); end
        checks++;
        if (rdata !== '0) begin failures++; $display("FAIL midclear_rst_rdata: got %h want 0", rdata); end
        checks++;
        if (clear_done !== 1'b0) begin failures++; $display("FAIL midclear_rst_done: got %b want 0", clear_done); end
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        nbusy = 0; done_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            if (busy !== 1'b1) break;
            nbusy++;
            if (clear_done === 1'b1) done_cnt++;
            tick();
        end
        checks++;
        if (nbusy != RT) begin failures++; $display("FAIL midclear_init_len: got %0d want %0d", nbusy, RT); end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL midclear_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 6000; c++) begin
            wren  = ($urandom_range(0, 1) == 1);
            waddr = AB'($urandom_range(0, RT - 1));
            if ($urandom_range(0, 7) == 0) waddr = AB'(mk($urandom_range(0, TC - 1), 0));
            wdata = $urandom;
            for (int p = 0; p < RP; p++) begin
                if ($urandom_range(0, 3) == 0) raddr[p*AB +: AB] = waddr;
                else raddr[p*AB +: AB] = AB'($urandom_range(0, RT - 1));
            end
            clear_req = ($urandom_range(0, 59) == 0);
            clear_tid = TB'($urandom_range(0, TC - 1));
            checks++;
            if (busy !== (sweep_q.size() != 0) || clear_done !== (sweep_q.size() == 1)) begin
                failures++;
                $display("FAIL rand_status c=%0d: got busy=%b done=%b want busy=%b done=%b",
                         c, busy, clear_done, sweep_q.size() != 0, sweep_q.size() == 1);
            end
            tick();
            for (int p = 0; p < RP; p++) begin
                if (exp_ok[p]) begin
                    checks++;
                    if (rdata[p*RW +: RW] !== exp_q[p]) begin
                        failures++;
                        $display("FAIL rand_read c=%0d p=%0d: got %h want %h", c, p, rdata[p*RW +: RW], exp_q[p]);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
